// File: rtl/keypad_scan.sv
// keypad_scan: 5x4 matrix keypad scanner with frame-level debounce.
// Drives one row low at a time, samples the synchronised columns at the
// end of each row slot, classifies every full frame as NONE / KEY / MULTI
// and debounces presses and releases over DEBOUNCE_FRAMES frames.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan #(
  parameter int unsigned SCAN_DIV        = 2000,
  parameter int unsigned DEBOUNCE_FRAMES = 8,
  parameter int unsigned REPEAT_FRAMES   = 2500
) (
  input  logic            clk,
  input  logic            rst,
  inout  wire logic [4:0] BTN_X,
  inout  wire logic [3:0] BTN_Y,
  output logic            key_valid,
  output logic [4:0]      key_code,
  output logic            key_held
);

  localparam int unsigned     SW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0]   SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [7:0]      DB_FRAMES = 8'(DEBOUNCE_FRAMES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRESS = 2'd1;
  localparam logic [1:0] S_HELD  = 2'd2;

  logic [SW-1:0] slot;
  logic [2:0]    row;
  logic [3:0]    y_s1, y_s2;
  logic          sample_en, frame_end;

  // Per-frame accumulator: acc_cnt saturates at 2 (meaning "two or more")
  logic [1:0]    acc_cnt;
  logic [4:0]    acc_code;
  logic [2:0]    row_hits;
  logic [1:0]    row_col;
  logic [2:0]    sum_cnt;
  logic [1:0]    merged_cnt;
  logic [4:0]    merged_code;

  // Registered frame result handed to the FSM one cycle after frame end
  logic          fr_valid;
  logic [1:0]    fr_cnt;
  logic [4:0]    fr_code;
  logic          fr_is_key, fr_is_multi;

  logic [1:0]    state;
  logic [7:0]    cnt;
  logic [7:0]    cnt_inc;
  logic [4:0]    cand;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RW         = $clog2(REPEAT_FRAMES + 1);
  localparam logic [RW-1:0] RF_LIMIT = RW'(REPEAT_FRAMES);
  logic [RW-1:0] rep_cnt;
  logic [RW-1:0] rep_inc;
  assign rep_inc = rep_cnt + RW'(1);
`endif

  // Selected row is pulled low; everything floats while in reset
  for (genvar i = 0; i < 5; i++) begin : g_row_drive
    assign BTN_X[i] = (!rst && (row == 3'(i))) ? 1'b0 : 1'bz;
  end

  assign sample_en = (slot == SLOT_LAST);
  assign frame_end = sample_en && (row == 3'd4);

  // Row/slot scan counters
  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
      row  <= '0;
    end else if (sample_en) begin
      slot <= '0;
      row  <= (row == 3'd4) ? 3'd0 : row + 3'd1;
    end else begin
      slot <= slot + SW'(1);
    end
  end

  // Two-flop column synchroniser (idle level is all-open)
  always_ff @(posedge clk) begin
    if (rst) begin
      y_s1 <= '1;
      y_s2 <= '1;
    end else begin
      y_s1 <= BTN_Y;
      y_s2 <= y_s1;
    end
  end

  // Merge the current row's contacts into the running frame tally
  always_comb begin
    row_hits = '0;
    row_col  = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      if (!y_s2[c]) begin
        row_hits = row_hits + 3'd1;
        row_col  = 2'(c);
      end
    end
    sum_cnt     = {1'b0, acc_cnt} + row_hits;
    merged_cnt  = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
    merged_code = (row_hits != 3'd0) ? {row, row_col} : acc_code;
  end

  // Accumulate per row sample; publish and clear at frame end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt  <= '0;
      acc_code <= '0;
      fr_valid <= 1'b0;
      fr_cnt   <= '0;
      fr_code  <= '0;
    end else begin
      fr_valid <= frame_end;
      if (frame_end) begin
        fr_cnt   <= merged_cnt;
        fr_code  <= merged_code;
        acc_cnt  <= '0;
        acc_code <= '0;
      end else if (sample_en) begin
        acc_cnt  <= merged_cnt;
        acc_code <= merged_code;
      end
    end
  end

  assign fr_is_key   = (fr_cnt == 2'd1);
  assign fr_is_multi = (fr_cnt == 2'd2);
  assign cnt_inc     = cnt + 8'd1;

  // Debounce FSM, stepped once per published frame result
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cand      <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      if (fr_valid) begin
        case (state)
          S_IDLE: begin
            if (fr_is_key) begin
              cand  <= fr_code;
              cnt   <= 8'd1;
              state <= S_PRESS;
            end
          end
          S_PRESS: begin
            if (fr_is_key && (fr_code == cand)) begin
              if (cnt_inc >= DB_FRAMES) begin
                key_code  <= cand;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                cnt       <= '0;
                state     <= S_HELD;
`ifdef KEYPAD_REPEAT_EN
                rep_cnt   <= '0;
`endif
              end else begin
                cnt <= cnt_inc;
              end
            end else if (fr_is_key) begin
              cand <= fr_code;
              cnt  <= 8'd1;
            end else begin
              cnt   <= '0;
              state <= S_IDLE;
            end
          end
          S_HELD: begin
            if (fr_is_key && (fr_code == key_code)) begin
              cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
              if (rep_inc >= RF_LIMIT) begin
                key_valid <= 1'b1;
                rep_cnt   <= '0;
              end else begin
                rep_cnt <= rep_inc;
              end
`endif
            end else begin
`ifdef KEYPAD_REPEAT_EN
              rep_cnt <= '0;
`endif
              // Ghosting (MULTI) neither releases nor resets the release count
              if (!fr_is_multi) begin
                if (cnt_inc >= DB_FRAMES) begin
                  key_held <= 1'b0;
                  cnt      <= '0;
                  state    <= S_IDLE;
                end else begin
                  cnt <= cnt_inc;
                end
              end
            end
          end
          default: begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Testbench for keypad_scan: models a 5x4 contact matrix with pull-ups,
// queues expected key events and compares them as key_valid pulses appear.
// Define KEYPAD_REPEAT_EN to also exercise auto-repeat.
module tb_keypad_scan;

  localparam int unsigned SD    = 4;
  localparam int unsigned DF    = 2;
  localparam int unsigned RF    = 3;
  localparam int unsigned FRAME = 5 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  wire  [4:0] BTN_X;
  wire  [3:0] BTN_Y;
  logic       key_valid;
  logic [4:0] key_code;
  logic       key_held;

  logic [3:0] keys [5];
  logic [3:0] y_model;
  logic [4:0] exp_q [$];
  logic       prev_valid = 1'b0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  for (genvar r = 0; r < 5; r++) begin : g_pull
    pullup pu_x (BTN_X[r]);
  end

  // Closed contact on a low row pulls its column low
  always_comb begin
    y_model = '1;
    for (int r = 0; r < 5; r++) begin
      if (BTN_X[r] === 1'b0) y_model = y_model & ~keys[r];
    end
  end
  assign BTN_Y = y_model;

  keypad_scan #(
    .SCAN_DIV(SD),
    .DEBOUNCE_FRAMES(DF),
    .REPEAT_FRAMES(RF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .BTN_X(BTN_X),
    .BTN_Y(BTN_Y),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_held(key_held)
  );

  // Scoreboard consumer: every key_valid pulse must match the queue head
  always @(negedge clk) begin
    logic [4:0] e;
    if (!rst && key_valid) begin
      checks++;
      if (prev_valid) begin
        errors++;
        $display("FAIL adjacent_valid: key_valid=1 on consecutive cycles, required 0");
      end
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: key_valid with key_code=%0d, required no event", key_code);
      end else begin
        e = exp_q.pop_front();
        if (key_code !== e) begin
          errors++;
          $display("FAIL event_code: key_code=%0d, required %0d", key_code, e);
        end
      end
    end
    prev_valid <= key_valid && !rst;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic wait_held(input logic lvl, input int unsigned bound, output int unsigned waited);
    waited = 0;
    while (key_held !== lvl && waited < bound) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic clear_keys();
    for (int r = 0; r < 5; r++) keys[r] = '0;
  endtask

  task automatic test_reset();
    int unsigned slot_m, row_m;
    logic [4:0] exp_x;
    clear_keys();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (BTN_X !== 5'b11111) begin
      errors++;
      $display("FAIL reset_rows_float: BTN_X=%b, required 11111", BTN_X);
    end
    rst = 1'b0;
    slot_m = 0;
    row_m  = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      slot_m++;
      if (slot_m == SD) begin
        slot_m = 0;
        row_m  = (row_m + 1) % 5;
      end
      exp_x = ~(5'b00001 << row_m);
      checks++;
      if (BTN_X !== exp_x) begin
        errors++;
        $display("FAIL row_scan: cycle %0d BTN_X=%b, required %b", k, BTN_X, exp_x);
      end
    end
    checks++;
    if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: key_valid=%b, required 0", key_valid); end
    checks++;
    if (key_code !== 5'd0) begin errors++; $display("FAIL reset_code: key_code=%0d, required 0", key_code); end
    checks++;
    if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held: key_held=%b, required 0", key_held); end
  endtask

  task automatic test_press_release();
    int unsigned w;
    keys[3][3] = 1'b1;
    exp_q.push_back(5'd15);
    wait_held(1'b1, 3 * FRAME + 5, w);
    checks++;
    if (key_held !== 1'b1) begin errors++; $display("FAIL press_held: key_held=%b after %0d cycles, required 1", key_held, w); end
    repeat (2 * FRAME) @(negedge clk);
    checks++;
    if (key_code !== 5'd15) begin errors++; $display("FAIL press_code: key_code=%0d, required 15", key_code); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL press_event: %0d expected events missing, required 0", exp_q.size()); end
    keys[3][3] = 1'b0;
    wait_held(1'b0, 3 * FRAME, w);
    checks++;
    if (key_held !== 1'b0 || w < FRAME) begin
      errors++;
      $display("FAIL release_held: key_held=%b after %0d cycles, required 0 within %0d..%0d", key_held, w, FRAME, 3 * FRAME);
    end
  endtask

  task automatic test_bounce();
    keys[1][1] = 1'b1;
    repeat (FRAME) @(negedge clk);
    keys[1][1] = 1'b0;
    repeat (4 * FRAME) @(negedge clk);
    checks++;
    if (key_held !== 1'b0) begin errors++; $display("FAIL bounce_held: key_held=%b, required 0", key_held); end
    checks++;
    if (key_code !== 5'd15) begin errors++; $display("FAIL bounce_code_hold: key_code=%0d, required 15", key_code); end
  endtask

  task automatic test_multi();
    int unsigned w;
    bit dropped;
    keys[3][3] = 1'b1;
    exp_q.push_back(5'd15);
    wait_held(1'b1, 3 * FRAME + 5, w);
    checks++;
    if (key_held !== 1'b1) begin errors++; $display("FAIL multi_first_held: key_held=%b, required 1", key_held); end
    keys[3][2] = 1'b1;
    dropped = 1'b0;
    repeat (5 * FRAME) begin
      @(negedge clk);
      if (key_held !== 1'b1) dropped = 1'b1;
    end
    keys[3][2] = 1'b0;
    repeat (2 * FRAME) begin
      @(negedge clk);
      if (key_held !== 1'b1) dropped = 1'b1;
    end
    checks++;
    if (dropped) begin errors++; $display("FAIL multi_ghost_release: key_held dropped to 0, required 1 throughout"); end
    keys[3][3] = 1'b0;
    keys[3][2] = 1'b1;
    exp_q.push_back(5'd14);
    wait_held(1'b0, 3 * FRAME, w);
    checks++;
    if (key_held !== 1'b0) begin errors++; $display("FAIL switch_release: key_held=%b, required 0", key_held); end
    wait_held(1'b1, 3 * FRAME, w);
    checks++;
    if (key_held !== 1'b1) begin errors++; $display("FAIL switch_press: key_held=%b, required 1", key_held); end
    @(negedge clk);
    checks++;
    if (key_code !== 5'd14) begin errors++; $display("FAIL switch_code: key_code=%0d, required 14", key_code); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL switch_events: %0d expected events missing, required 0", exp_q.size()); end
    keys[3][2] = 1'b0;
    wait_held(1'b0, 3 * FRAME, w);
  endtask

  task automatic test_reset_mid();
    int unsigned w;
    keys[0][2] = 1'b1;
    repeat (25) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (key_code !== 5'd0) begin errors++; $display("FAIL midreset_code: key_code=%0d, required 0", key_code); end
    exp_q.push_back(5'd2);
    repeat (FRAME + 5) @(negedge clk);
    checks++;
    if (key_held !== 1'b0 || exp_q.size() != 1) begin
      errors++;
      $display("FAIL midreset_early: key_held=%b pending=%0d, required 0 and 1", key_held, exp_q.size());
    end
    wait_held(1'b1, 3 * FRAME, w);
    checks++;
    if (key_held !== 1'b1) begin errors++; $display("FAIL midreset_press: key_held=%b, required 1", key_held); end
    @(negedge clk);
    checks++;
    if (key_code !== 5'd2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_event: key_code=%0d pending=%0d, required 2 and 0", key_code, exp_q.size());
    end
    keys[0][2] = 1'b0;
    wait_held(1'b0, 3 * FRAME, w);
  endtask

`ifdef KEYPAD_REPEAT_EN
  task automatic test_repeat();
    int unsigned w;
    keys[3][3] = 1'b1;
    exp_q.push_back(5'd15);
    wait_held(1'b1, 3 * FRAME + 5, w);
    for (int k = 0; k < 3; k++) exp_q.push_back(5'd15);
    repeat (3 * RF * FRAME + 10) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL repeat_events: %0d repeat events missing, required 0", exp_q.size()); end
    keys[3][3] = 1'b0;
    wait_held(1'b0, 3 * FRAME, w);
    checks++;
    if (key_held !== 1'b0) begin errors++; $display("FAIL repeat_release: key_held=%b, required 0", key_held); end
  endtask
`endif

  initial begin
    test_reset();
    test_press_release();
    test_bounce();
    test_multi();
    test_reset_mid();
`ifdef KEYPAD_REPEAT_EN
    test_repeat();
`endif
    repeat (2 * FRAME) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue: %0d events never seen, required 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Matrix-keypad front end for the BABA Is You game: drives the 5 row lines of the board's 5x4 button array one at a time, reads the 4 column lines, and debounces the result. It emits a one-cycle key event with a 5-bit key code to the game-logic FSM. It sits directly upstream of the game logic in GameTop and owns the BTN_X/BTN_Y pins.

## Interface

- SCAN_DIV, 2000: clk cycles each row stays selected (20 us at 100 MHz); must be >= 4.
- DEBOUNCE_FRAMES, 8: consecutive identical frames needed to accept a press or a release (1..255).
- REPEAT_FRAMES, 2500: frames between auto-repeat events (used only with the Configuration macro).

- clk  input  1  system clock (100 MHz).
- rst  input  1  synchronous, active-high reset.
- BTN_X  inout  5  row lines; the selected row is driven 0, all others 'z'.
- BTN_Y  inout  4  column lines; never driven (always 'z'), read only; external pull-ups; 0 = key closed.
- key_valid  output  1  one-cycle pulse: new key accepted.
- key_code  output  5  row*4+col of the accepted key (0..19); holds its value until the next event.
- key_held  output  1  high while the accepted key is still debounced-pressed.

## Operation

- Row counter `row` (0..4) and slot counter (0..SCAN_DIV-1). `row` advances when the slot counter wraps, and wraps 4->0. One frame = 5*SCAN_DIV cycles.
- BTN_Y passes through a 2-flop synchronizer. The column sample is taken on the last cycle of each slot, after settling.
- Per-frame accumulator: count of closed contacts, plus the code of the last one seen. At the wrap from row 4 to row 0, the frame result is:
  - NONE if the count is 0;
  - KEY(code) if the count is exactly 1;
  - MULTI if the count is 2 or more.
  The accumulator then clears.
- FSM, evaluated once per frame end:
  - IDLE: on KEY(c), latch cand=c, cnt=1, go to PRESS. Otherwise stay.
  - PRESS:
    - KEY(cand): cnt++. When cnt reaches DEBOUNCE_FRAMES, set key_code=cand, pulse key_valid, set key_held=1, go to HELD.
    - KEY(other): cand=other, cnt=1.
    - NONE or MULTI: go to IDLE.
  - HELD:
    - KEY(key_code): cnt=0.
    - MULTI: no change to cnt (ghosting never counts as a release).
    - NONE or KEY(other): cnt++. When cnt reaches DEBOUNCE_FRAMES, set key_held=0 and go to IDLE.
- A different key pressed while one is held is reported only after the held key is released and the new key debounces from IDLE.
- key_code width: {row*4+col}, computed as (row<<2)|col in 5 bits.

## Timing

- Reset values:
  - row=0, slot=0, accumulator clear, state IDLE, cnt=0.
  - key_valid=0, key_code=0, key_held=0.
  - BTN_X = all 'z' while rst is high; row 0 is driven 0 from the first cycle after reset.
- Reset mid-operation: all state clears on the next edge. No key_valid may follow from a pre-reset frame.
- key_valid rises in the cycle after the frame-end evaluation, lasts exactly 1 cycle, and never occurs on two adjacent cycles.
- Press latency, from contact closure to key_valid: between DEBOUNCE_FRAMES and DEBOUNCE_FRAMES+1 frames, plus 3 cycles.
- key_held falls in the same cycle position, DEBOUNCE_FRAMES frame ends after the last matching frame.

## Configuration

- KEYPAD_REPEAT_EN:
  - Defined: while in HELD, a separate frame counter runs. Every REPEAT_FRAMES frames in which the result is KEY(key_code), it re-pulses key_valid with the same key_code. The counter clears on entry to HELD and on any non-matching frame.
  - Undefined: exactly one key_valid per press; REPEAT_FRAMES is unused and the repeat counter is not synthesized.

## Test plan

All scenarios use SCAN_DIV=4 and DEBOUNCE_FRAMES=2, so one frame is 20 cycles.

- Reset with no keys pressed -> BTN_X=zzzzz during rst, then 1 row low per 4 cycles in order 0..4; key_valid, key_code and key_held stay 0.
- Close row 3 / col 3 contact (BTN_X=10111 sees BTN_Y=0111) -> exactly one key_valid, key_code=15, key_held=1 within 3 frames. Open the contact -> key_held=0 after 2-3 frames.
- Close row 1 / col 1 (BTN_X=11101, BTN_Y=1101) for 1 frame only, then release -> no key_valid (bounce rejected).
- Hold row 3 col 3, then add row 3 col 2 (MULTI) for 5 frames, then return to col 3 only -> key_held stays 1 and no additional key_valid. Then release col 3 and press row 3 col 2 -> key_held=0, then key_valid with key_code=14.
- Assert rst for 1 cycle while in PRESS with cnt=1 -> state IDLE, key_valid never pulses for that contact until 2 new matching frames complete.
- With KEYPAD_REPEAT_EN and REPEAT_FRAMES=3: hold code 15 for 12 frames -> key_valid at the initial accept and then every 3 frames, always with key_code=15.
